// File: rtl/tone_sequencer_if.sv
// Control, melody-ROM and audio-level signals between the tone sequencer and its host.
// slave is the sequencer's view; master is the view of whatever drives play/stop and serves the ROM.
interface tone_sequencer_if;
  logic        play;
  logic        stop;
  logic        loop;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic [16:0] level;
  logic [3:0]  note_idx;
  logic        busy;
  logic        done;

  modport master (
    output play, stop, loop, rom_data,
    input  rom_addr, level, note_idx, busy, done
  );

  modport slave (
    input  play, stop, loop, rom_data,
    output rom_addr, level, note_idx, busy, done
  );
endinterface

// File: rtl/tone_sequencer.sv
// Walks a 16-entry melody ROM, producing an enveloped square wave per entry for the PWM stage.
// Entry format: [7:4] note (1..12 tones, others rest), [3:0] duration in ticks (0 = end marker).
module tone_sequencer #(
  parameter int unsigned CLK_HZ      = 100000000,
  parameter int unsigned TICK_CYCLES = CLK_HZ / 16,
  parameter logic [16:0] AMP_MAX     = 17'h10000,
  parameter logic [16:0] DECAY_STEP  = 17'h01000
) (
  input logic             CLK100MHZ,
  input logic             reset,
  tone_sequencer_if.slave sif
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY} state_t;

  // Half-period in clock cycles; rests get 1 so the phase counter stays well defined.
  function automatic logic [16:0] half_of(input int n);
    int unsigned f;
    case (n)
      1:       f = 440;
      2:       f = 466;
      3:       f = 494;
      4:       f = 523;
      5:       f = 554;
      6:       f = 587;
      7:       f = 622;
      8:       f = 659;
      9:       f = 698;
      10:      f = 740;
      11:      f = 784;
      12:      f = 831;
      default: f = 0;
    endcase
    if (f == 0 || CLK_HZ < 2 * f) return 17'd1;
    return 17'(CLK_HZ / (2 * f));
  endfunction

  function automatic logic is_tone(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd12);
  endfunction

  logic [16:0] half_lut [16];

  for (genvar gi = 0; gi < 16; gi++) begin : g_half
    localparam logic [16:0] HALF = half_of(gi);
    assign half_lut[gi] = HALF;
  end

  state_t        state_reg, state_next;
  logic [3:0]    rom_addr_reg, rom_addr_next;
  logic [16:0]   level_reg, level_next;
  logic [3:0]    note_idx_reg, note_idx_next;
  logic          busy_reg, busy_next;
  logic          done_reg, done_next;
  logic [16:0]   amp_reg, amp_next;
  logic [16:0]   half_cnt_reg, half_cnt_next;
  logic [TW-1:0] tick_cnt_reg, tick_cnt_next;
  logic [3:0]    dur_cnt_reg, dur_cnt_next;
  logic          phase_reg, phase_next;
  logic          wrap_reg, wrap_next;

  logic [3:0]  rom_note;
  logic [3:0]  rom_dur;
  logic        fetch_end;
  logic        tick;
  logic        note_end;
  logic [16:0] amp_dec;

  assign rom_note  = sif.rom_data[7:4];
  assign rom_dur   = sif.rom_data[3:0];
  // wrap_reg marks that the previous note was the one at address 15
  assign fetch_end = (rom_dur == 4'd0) || wrap_reg;
  assign tick      = (tick_cnt_reg == '0);
  assign note_end  = tick && (dur_cnt_reg == 4'd1);
  assign amp_dec   = (amp_reg > DECAY_STEP) ? (amp_reg - DECAY_STEP) : 17'd0;

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_reg    <= IDLE;
      rom_addr_reg <= '0;
      level_reg    <= '0;
      note_idx_reg <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      amp_reg      <= '0;
      half_cnt_reg <= '0;
      tick_cnt_reg <= '0;
      dur_cnt_reg  <= '0;
      phase_reg    <= 1'b0;
      wrap_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      level_reg    <= level_next;
      note_idx_reg <= note_idx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      amp_reg      <= amp_next;
      half_cnt_reg <= half_cnt_next;
      tick_cnt_reg <= tick_cnt_next;
      dur_cnt_reg  <= dur_cnt_next;
      phase_reg    <= phase_next;
      wrap_reg     <= wrap_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    if (sif.stop) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (sif.play) state_next = FETCH;
        FETCH:   if (fetch_end) state_next = sif.loop ? FETCH : IDLE;
                 else           state_next = PLAY;
        PLAY:    if (note_end) state_next = FETCH;
        default: state_next = IDLE;
      endcase
    end
  end

  // level is computed from next-cycle phase/amp so the registered word lines up with the phase
  always_comb begin
    rom_addr_next = rom_addr_reg;
    level_next    = '0;
    note_idx_next = note_idx_reg;
    done_next     = 1'b0;
    amp_next      = amp_reg;
    half_cnt_next = half_cnt_reg;
    tick_cnt_next = tick_cnt_reg;
    dur_cnt_next  = dur_cnt_reg;
    phase_next    = phase_reg;
    wrap_next     = wrap_reg;

    case (state_reg)
      IDLE: begin
        note_idx_next = '0;
        wrap_next     = 1'b0;
        if (sif.play) rom_addr_next = '0;
      end
      FETCH: begin
        if (fetch_end) begin
          wrap_next = 1'b0;
          if (sif.loop) begin
            rom_addr_next = '0;
          end else begin
            done_next     = 1'b1;
            note_idx_next = '0;
          end
        end else begin
          note_idx_next = rom_note;
          dur_cnt_next  = rom_dur;
          amp_next      = AMP_MAX;
          phase_next    = 1'b1;
          half_cnt_next = half_lut[rom_note] - 17'd1;
          tick_cnt_next = TICK_LAST;
          level_next    = is_tone(rom_note) ? AMP_MAX : 17'd0;
        end
      end
      PLAY: begin
        if (half_cnt_reg == '0) begin
          half_cnt_next = half_lut[note_idx_reg] - 17'd1;
          phase_next    = ~phase_reg;
        end else begin
          half_cnt_next = half_cnt_reg - 17'd1;
        end
        if (tick) begin
          tick_cnt_next = TICK_LAST;
          amp_next      = amp_dec;
          dur_cnt_next  = dur_cnt_reg - 4'd1;
        end else begin
          tick_cnt_next = tick_cnt_reg - TW'(1);
        end
        if (note_end) begin
          rom_addr_next = rom_addr_reg + 4'd1;
          wrap_next     = (rom_addr_reg == 4'd15);
        end else begin
          level_next = (phase_next && is_tone(note_idx_reg)) ? amp_next : 17'd0;
        end
      end
      default: ;
    endcase

    if (sif.stop) begin
      rom_addr_next = rom_addr_reg;
      level_next    = '0;
      note_idx_next = '0;
      done_next     = 1'b0;
      wrap_next     = 1'b0;
    end

    busy_next = (state_next != IDLE);
  end

  assign sif.rom_addr = rom_addr_reg;
  assign sif.level    = level_reg;
  assign sif.note_idx = note_idx_reg;
  assign sif.busy     = busy_reg;
  assign sif.done     = done_reg;

endmodule

// File: tb/tb_tone_sequencer.sv
// Bench for tone_sequencer: elapsed-time reference model compared every cycle, plus directed literal checks.
// Scaled clock (CLK_HZ=100000) keeps half-periods short: note 1 -> 113 cycles, note 12 -> 60 cycles.
module tb_tone_sequencer;
  localparam int unsigned CLK_HZ = 100000;
  localparam int unsigned TICK   = 500;
  localparam logic [16:0] AMP    = 17'h10000;
  localparam logic [16:0] STEP   = 17'h02000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  tone_sequencer_if sif ();
  logic [7:0] rom [16];
  assign sif.rom_data = rom[sif.rom_addr];

  tone_sequencer #(
    .CLK_HZ(CLK_HZ), .TICK_CYCLES(TICK), .AMP_MAX(AMP), .DECAY_STEP(STEP)
  ) dut (
    .CLK100MHZ(clk),
    .reset(reset),
    .sif(sif)
  );

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned freq(input int n);
    case (n)
      1: return 440;   2: return 466;   3: return 494;   4: return 523;
      5: return 554;   6: return 587;   7: return 622;   8: return 659;
      9: return 698;   10: return 740;  11: return 784;  12: return 831;
      default: return 0;
    endcase
  endfunction

  function automatic int unsigned half_period(input int n);
    return (freq(n) == 0) ? 1 : CLK_HZ / (2 * freq(n));
  endfunction

  function automatic logic [16:0] amp_at(input int unsigned t);
    longint k;
    k = longint'(t / TICK);
    if (longint'(AMP) > k * longint'(STEP)) return 17'(longint'(AMP) - k * longint'(STEP));
    return 17'd0;
  endfunction

  int          m_state = 0;   // 0 idle, 1 fetch, 2 play
  int          m_addr = 0;
  int          m_note = 0;
  int          m_dur = 0;
  int unsigned m_t = 0;       // cycles elapsed since the note started sounding
  bit          m_wrap = 1'b0;
  logic [16:0] e_level = '0;
  bit          e_busy = 1'b0;
  bit          e_done = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] ent;
    e_done = 1'b0;
    ent = rom[m_addr[3:0]];
    if (reset) begin
      m_state = 0; m_addr = 0; m_note = 0; m_wrap = 1'b0; m_t = 0;
    end else if (sif.stop) begin
      m_state = 0; m_note = 0; m_wrap = 1'b0;
    end else begin
      case (m_state)
        0: if (sif.play) begin m_state = 1; m_addr = 0; end
        1: begin
          if (ent[3:0] == 4'd0 || m_wrap) begin
            m_wrap = 1'b0;
            if (sif.loop) m_addr = 0;
            else begin m_state = 0; m_note = 0; e_done = 1'b1; end
          end else begin
            m_note = int'(ent[7:4]); m_dur = int'(ent[3:0]); m_t = 0; m_state = 2;
          end
        end
        default: begin
          m_t++;
          if (m_t == m_dur * TICK) begin
            m_wrap = (m_addr == 15);
            m_addr = (m_addr + 1) % 16;
            m_state = 1;
          end
        end
      endcase
    end
    e_busy = (m_state != 0);
    e_level = (m_state == 2 && m_note >= 1 && m_note <= 12 &&
               ((m_t / half_period(m_note)) % 2) == 0) ? amp_at(m_t) : 17'd0;
  end

  always @(negedge clk) begin
    if (cmp_on && errors < 50) begin
      check("cyc_level",    32'(sif.level),    32'(e_level));
      check("cyc_note_idx", 32'(sif.note_idx), 32'(m_note));
      check("cyc_busy",     32'(sif.busy),     32'(e_busy));
      check("cyc_done",     32'(sif.done),     32'(e_done));
      check("cyc_rom_addr", 32'(sif.rom_addr), 32'(m_addr));
    end
    if (sif.done) done_cnt++;
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  // Leaves the bench at the negedge of the FETCH cycle for address 0.
  task automatic start();
    sif.play = 1'b1;
    step(1);
    sif.play = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (sif.busy && k < budget) begin step(1); k++; end
    check(name, 32'(sif.busy), 32'd0);
  endtask

  task automatic wait_note(input string name, input logic [3:0] n, input int budget);
    int k = 0;
    while (sif.note_idx != n && k < budget) begin step(1); k++; end
    check(name, 32'(sif.note_idx), 32'(n));
  endtask

  task automatic wait_addr(input string name, input logic [3:0] a, input int budget);
    int k = 0;
    while (sif.rom_addr != a && k < budget) begin step(1); k++; end
    check(name, 32'(sif.rom_addr), 32'(a));
  endtask

  initial begin : timeout
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  initial begin : stim
    int d0;
    sif.play = 1'b0; sif.stop = 1'b0; sif.loop = 1'b0;
    rom_clear();
    reset = 1'b1;
    step(1);
    cmp_on = 1'b1;
    check("rst_level", 32'(sif.level), 32'd0);
    check("rst_busy",  32'(sif.busy),  32'd0);
    check("rst_addr",  32'(sif.rom_addr), 32'd0);
    step(2);
    reset = 1'b0;
    step(2);

    // single tone: note 1, four ticks
    rom[0] = 8'h14;
    d0 = done_cnt;
    start();
    check("t1_fetch_busy",  32'(sif.busy),  32'd1);
    check("t1_fetch_level", 32'(sif.level), 32'd0);
    step(1);
    check("t1_first_level", 32'(sif.level), 32'h10000);
    check("t1_note",        32'(sif.note_idx), 32'd1);
    step(113);
    check("t1_low_at_113",  32'(sif.level), 32'd0);
    step(113);
    check("t1_high_at_226", 32'(sif.level), 32'h10000);
    step(274);
    check("t1_decay_at_500", 32'(sif.level), 32'h0E000);
    step(1500);
    check("t1_end_fetch_addr", 32'(sif.rom_addr), 32'd1);
    check("t1_end_fetch_level", 32'(sif.level), 32'd0);
    step(1);
    check("t1_done",  32'(sif.done), 32'd1);
    check("t1_idle",  32'(sif.busy), 32'd0);
    step(1);
    check("t1_done_pulse", 32'(sif.done), 32'd0);
    step(1);
    check("t1_done_count", 32'(done_cnt - d0), 32'd1);

    // envelope with saturation at zero
    rom_clear();
    rom[0] = 8'h1F;
    start();
    step(1);
    step(3390);
    check("t2_amp_k6", 32'(sif.level), 32'h04000);
    step(110);
    check("t2_amp_k7", 32'(sif.level), 32'h02000);
    step(568);
    check("t2_amp_sat", 32'(sif.level), 32'd0);
    wait_idle("t2_idle", 4000);
    step(2);

    // rest and sequencing
    rom_clear();
    rom[0] = 8'h12; rom[1] = 8'h02; rom[2] = 8'hC1;
    d0 = done_cnt;
    start();
    step(1);
    check("t3_note1", 32'(sif.note_idx), 32'd1);
    step(1000);
    check("t3_fetch_addr1", 32'(sif.rom_addr), 32'd1);
    step(1);
    check("t3_rest_busy",  32'(sif.busy),  32'd1);
    check("t3_rest_level", 32'(sif.level), 32'd0);
    wait_note("t3_note12", 4'd12, 1100);
    check("t3_addr2",    32'(sif.rom_addr), 32'd2);
    check("t3_c_high",   32'(sif.level), 32'h10000);
    step(60);
    check("t3_c_low_60", 32'(sif.level), 32'd0);
    step(60);
    check("t3_c_high_120", 32'(sif.level), 32'h10000);
    wait_idle("t3_idle", 600);
    check("t3_addr3", 32'(sif.rom_addr), 32'd3);
    step(2);
    check("t3_done_once", 32'(done_cnt - d0), 32'd1);

    // loop and wrap
    for (int i = 0; i < 16; i++) rom[i] = 8'h11;
    sif.loop = 1'b1;
    d0 = done_cnt;
    start();
    wait_addr("t4_addr15", 4'd15, 16 * 502);
    step(1);
    wait_addr("t4_wrap0", 4'd0, 600);
    check("t4_busy_wrap", 32'(sif.busy), 32'd1);
    step(3);
    check("t4_replay_note", 32'(sif.note_idx), 32'd1);
    check("t4_replay_level", 32'(sif.level), 32'h10000);
    sif.stop = 1'b1;
    step(1);
    sif.stop = 1'b0;
    sif.loop = 1'b0;
    check("t4_stop_busy",  32'(sif.busy),  32'd0);
    check("t4_stop_level", 32'(sif.level), 32'd0);
    step(2);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);

    // reset mid-note
    rom_clear();
    rom[0] = 8'h12; rom[1] = 8'h14;
    start();
    step(1 + 1000 + 1 + 50);
    check("t5_pre_addr",  32'(sif.rom_addr), 32'd1);
    check("t5_pre_level", 32'(sif.level), 32'h10000);
    reset = 1'b1;
    step(1);
    check("t5_rst_level", 32'(sif.level), 32'd0);
    check("t5_rst_note",  32'(sif.note_idx), 32'd0);
    check("t5_rst_busy",  32'(sif.busy), 32'd0);
    check("t5_rst_addr",  32'(sif.rom_addr), 32'd0);
    reset = 1'b0;
    step(1);

    // play and stop together in idle
    sif.play = 1'b1; sif.stop = 1'b1;
    step(2);
    check("t5_stop_wins", 32'(sif.busy), 32'd0);
    sif.play = 1'b0; sif.stop = 1'b0;
    step(1);

    // play while busy is ignored
    rom_clear();
    rom[0] = 8'h14;
    d0 = done_cnt;
    start();
    step(300);
    sif.play = 1'b1;
    step(5);
    sif.play = 1'b0;
    check("t5_play_busy_note", 32'(sif.note_idx), 32'd1);
    wait_idle("t5_idle", 3000);
    step(2);
    check("t5_done_once", 32'(done_cnt - d0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Melody stage that sits directly upstream of the PWM/speaker path in the music box synth.
- Walks a 16-entry external melody ROM and generates a square wave at each entry's note frequency, with a linear decay envelope per note.
- Output is the 17-bit `level` word consumed by the PWM comparator; full scale is 17'h10000, which gives 100 % duty against the 16-bit PWM counter.
- Replaces the fixed 440 Hz divider with a sequenced, enveloped tone source.

Parameters:
- CLK_HZ, 100000000, system clock frequency. Must satisfy CLK_HZ/880 < 131072.
- TICK_CYCLES, CLK_HZ/16, clock cycles per duration/envelope tick.
- AMP_MAX, 17'h10000, envelope start amplitude. Must be ≤ 17'h10000.
- DECAY_STEP, 17'h1000, amplitude decrement per tick. Saturates at 0.

Ports:
- CLK100MHZ  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  start request; sampled in IDLE only
- stop  in  1  synchronous abort; has priority over play
- loop  in  1  at end of melody, restart from address 0 instead of finishing
- rom_addr  out  4  melody ROM address, registered
- rom_data  in  8  melody entry, combinational read of rom_addr: [7:4] note, [3:0] duration in ticks
- level  out  17  amplitude word to the PWM stage, registered
- note_idx  out  4  note currently sounding (0 = rest/idle)
- busy  out  1  high in FETCH and PLAY
- done  out  1  one-cycle pulse when a non-looping melody ends

Behaviour:
- Clocking and reset: one clock, CLK100MHZ. Reset is synchronous and active-high; in reset all outputs and internal counters go to 0 and the FSM goes to IDLE.
- States: IDLE, FETCH, PLAY.
- IDLE: level=0, note_idx=0, busy=0. play=1 && stop=0 → FETCH next cycle with rom_addr=0.
- FETCH (exactly 1 cycle): decode rom_data.
  - Duration 0 is the end marker.
  - Address 15 completing PLAY also counts as end; the next address wraps to 0.
  - End with loop=1: rom_addr←0, stay in FETCH.
  - End with loop=0: → IDLE and pulse done for one cycle.
  - Otherwise load: note_idx←note, dur_cnt←duration, amp←AMP_MAX, phase←1, half_cnt←HALF(note)-1, tick_cnt←TICK_CYCLES-1; → PLAY.
- Note table: HALF(n) = CLK_HZ/(2*F_n), integer division computed at elaboration. F_1..F_12 = 440, 466, 494, 523, 554, 587, 622, 659, 698, 740, 784, 831 Hz. Notes 0 and 13–15 are rests.
- PLAY, phase generator: half_cnt decrements every cycle. At 0 it reloads HALF-1 and toggles phase.
- PLAY, tick counter: tick_cnt decrements every cycle; at 0 it reloads and raises a tick.
- PLAY, on each tick:
  - amp←amp-DECAY_STEP if amp>DECAY_STEP, else 0.
  - dur_cnt decrements. When it reaches 0, rom_addr increments (15 wraps to 0 and is treated as end) and the FSM goes to FETCH.
- level: registered as (phase && note is not a rest) ? amp : 0. It follows phase with a 1-cycle delay; the first PLAY-cycle level equals AMP_MAX for a tone.
- Gaps: a fetch gap of 1 cycle between notes is allowed; level holds 0 during FETCH.
- stop=1 in any state → IDLE next cycle, level=0, no done pulse.
- play while busy is ignored. play and stop in the same cycle → stop wins.
- A reset asserted mid-note takes effect on the next edge, regardless of state.
- Width rules:
  - amp and level: 17 bits unsigned, never exceed AMP_MAX.
  - half_cnt: 17 bits.
  - tick_cnt: $clog2(TICK_CYCLES) bits.

Test Plan:
- Single tone. Defaults except TICK_CYCLES=1000000; ROM[0]=8'h14, ROM[1]=0; pulse play. Required: level toggles between 17'h10000 and 0 every 113636 cycles; after 4 ticks → done pulse, busy=0, level=0.
- Envelope. TICK_CYCLES=1000, HALF irrelevant; ROM[0]=8'h1F. Required: high-phase level steps 10000, F000, E000… by 17'h1000 per 1000 cycles, saturating at 0 (never wraps).
- Rest and sequencing. ROM = {8'h12, 8'h02, 8'hC1, 8'h00}, TICK_CYCLES=500. Required: note_idx 1 (1000 cycles), 0 with level=0 (1000 cycles), 12 with half-period 60168 cycles; rom_addr visits 0,1,2,3; done asserted exactly once.
- Loop and wrap. All 16 entries 8'h11, loop=1. Required: after address 15, rom_addr returns to 0 with no done pulse; busy stays high; stop then gives IDLE and level=0 on the next cycle.
- Abort and priority. Mid-note assert reset → all outputs 0 next edge. play and stop together in IDLE → stays IDLE. play during PLAY → sequence unaffected.
